pll_lock_supervisor: RTL and testbench

Sequences the board PLL (EHXPLLL wrapper, 25 MHz reference) from power-up to a usable clock. The block drives the PLL reset, waits for lock with timeout and retry, and qualifies lock stability. It then releases a system reset and serves dynamic phase-step requests (PHASESEL/PHASEDIR/PHASESTEP). It runs on the free-running reference clock so it keeps working while the PLL output is absent.

---
 rtl/pll_lock_supervisor.sv | 189 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor: PLL reset sequencing, lock qualification, phase stepping
// Rev 1.0
// ============================================================================
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 250,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 2500,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  input  logic       ps_req,
  input  logic       ps_dir,
  input  logic [1:0] ps_sel,
  output logic       ps_ack,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep
);

  // One shared counter, sized for the longest interval (phase-step phases need up to 4).
  localparam int CNT_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_ABC = (CNT_AB > STABLE_CYCLES) ? CNT_AB : STABLE_CYCLES;
  localparam int CNT_TOP = (CNT_ABC > 4) ? CNT_ABC : 4;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETUP_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_PULSE_LAST   = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_RECOVER_LAST = CNT_W'(1);
  localparam logic [3:0]       C_RETRY_LIMIT  = 4'(MAX_RETRIES);

  localparam logic [2:0] C_ST_HOLD       = 3'd0;
  localparam logic [2:0] C_ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] C_ST_STABLE     = 3'd2;
  localparam logic [2:0] C_ST_RUN        = 3'd3;
  localparam logic [2:0] C_ST_FAILED     = 3'd4;
  localparam logic [2:0] C_ST_PH_SETUP   = 3'd5;
  localparam logic [2:0] C_ST_PH_PULSE   = 3'd6;
  localparam logic [2:0] C_ST_PH_RECOVER = 3'd7;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync;
  logic             r_locked_s;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_retry_inc;

  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_retry_inc = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_sync        <= 1'b0;
      r_locked_s    <= 1'b0;
      r_state       <= C_ST_HOLD;
      r_cnt         <= '0;
      pll_reset     <= 1'b1;
      sys_reset_n   <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
      retry_count   <= 4'd0;
      ps_ack        <= 1'b0;
      pll_phasesel  <= 2'd0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
    end else begin
      r_sync     <= pll_locked;
      r_locked_s <= r_sync;
      ps_ack     <= 1'b0;
      case (r_state)
        C_ST_HOLD: begin
          if (r_cnt == C_RST_LAST) begin
            r_state   <= C_ST_WAIT_LOCK;
            r_cnt     <= '0;
            pll_reset <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        C_ST_WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= C_ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LOCK_LAST) begin
            retry_count <= w_retry_inc;
            r_cnt       <= '0;
            pll_reset   <= 1'b1;
            if (w_retry_inc == C_RETRY_LIMIT) begin
              r_state <= C_ST_FAILED;
              fail    <= 1'b1;
            end else begin
              r_state <= C_ST_HOLD;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        C_ST_STABLE: begin
          // A dropout restarts qualification without costing a retry.
          if (!r_locked_s) begin
            r_state <= C_ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STABLE_LAST) begin
            r_state     <= C_ST_RUN;
            r_cnt       <= '0;
            ready       <= 1'b1;
            sys_reset_n <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        C_ST_RUN: begin
          retry_count <= 4'd0;
          if (!r_locked_s) begin
            r_state     <= C_ST_HOLD;
            r_cnt       <= '0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
          end else if (ps_req) begin
            r_state      <= C_ST_PH_SETUP;
            r_cnt        <= '0;
            pll_phasesel <= ps_sel;
            pll_phasedir <= ps_dir;
          end
        end
        C_ST_FAILED: begin
          pll_reset   <= 1'b1;
          fail        <= 1'b1;
          sys_reset_n <= 1'b0;
        end
        C_ST_PH_SETUP, C_ST_PH_PULSE, C_ST_PH_RECOVER: begin
          if (!r_locked_s) begin
            r_state       <= C_ST_HOLD;
            r_cnt         <= '0;
            pll_reset     <= 1'b1;
            sys_reset_n   <= 1'b0;
            ready         <= 1'b0;
            pll_phasestep <= 1'b1;
          end else if (r_state == C_ST_PH_SETUP) begin
            if (r_cnt == C_SETUP_LAST) begin
              r_state       <= C_ST_PH_PULSE;
              r_cnt         <= '0;
              pll_phasestep <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (r_state == C_ST_PH_PULSE) begin
            if (r_cnt == C_PULSE_LAST) begin
              r_state       <= C_ST_PH_RECOVER;
              r_cnt         <= '0;
              pll_phasestep <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            // Ack is registered one cycle early so it lands in the final recover cycle.
            if (r_cnt == C_RECOVER_LAST) begin
              r_state <= C_ST_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt  <= w_cnt_inc;
              ps_ack <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= C_ST_HOLD;
          r_cnt     <= '0;
          pll_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_supervisor: directed bench for pll_lock_supervisor
// Rev 1.0
// ============================================================================
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic       ps_req;
  logic       ps_dir;
  logic [1:0] ps_sel;
  logic       ps_ack;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;

  int tests = 0;
  int fails = 0;

  always #20 clk = ~clk;

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk_in(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .pll_reset(pll_reset), .sys_reset_n(sys_reset_n), .ready(ready), .fail(fail),
    .retry_count(retry_count), .ps_req(ps_req), .ps_dir(ps_dir), .ps_sel(ps_sel),
    .ps_ack(ps_ack), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; ps_req = 1'b0; ps_dir = 1'b0; ps_sel = 2'd0;
    repeat (3) tick();
    tests++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL reset_pll_reset got %b want 1", pll_reset); end
    tests++; if (sys_reset_n !== 1'b0) begin fails++; $display("FAIL reset_sys_reset_n got %b want 0", sys_reset_n); end
    tests++; if (ready !== 1'b0 || fail !== 1'b0) begin fails++; $display("FAIL reset_ready_fail got %b%b want 00", ready, fail); end
    tests++; if (retry_count !== 4'd0 || ps_ack !== 1'b0) begin fails++; $display("FAIL reset_retry_ack got %0d/%b want 0/0", retry_count, ps_ack); end
    tests++; if (pll_phasesel !== 2'd0 || pll_phasedir !== 1'b0 || pll_phasestep !== 1'b1) begin
      fails++; $display("FAIL reset_phase got sel=%0d dir=%b step=%b want 0/0/1", pll_phasesel, pll_phasedir, pll_phasestep);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_bringup();
    int n;
    n = 0;
    while (pll_reset === 1'b1 && n < 50) begin n++; tick(); end
    tests++; if (n != 4) begin fails++; $display("FAIL bringup_hold_len got %0d want 4", n); end
    tick(); tick();
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
    tests++; if (n != 11) begin fails++; $display("FAIL bringup_ready_delay got %0d want 11", n); end
    tests++; if (sys_reset_n !== 1'b1 || fail !== 1'b0 || retry_count !== 4'd0) begin
      fails++; $display("FAIL bringup_outputs got srn=%b fail=%b retry=%0d want 1/0/0", sys_reset_n, fail, retry_count);
    end
  endtask

  task automatic test_phase_step();
    int p;
    logic exp_step, exp_ack;
    ps_sel = 2'd2; ps_dir = 1'b0; ps_req = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      p = (k - 1) % 9 + 1;
      exp_step = (p >= 3 && p <= 6) ? 1'b0 : 1'b1;
      exp_ack  = (p == 8);
      tests++; if (pll_phasestep !== exp_step) begin fails++; $display("FAIL ps_step k=%0d got %b want %b", k, pll_phasestep, exp_step); end
      tests++; if (ps_ack !== exp_ack) begin fails++; $display("FAIL ps_ack k=%0d got %b want %b", k, ps_ack, exp_ack); end
      tests++; if (ready !== 1'b1 || sys_reset_n !== 1'b1) begin fails++; $display("FAIL ps_ready k=%0d got %b%b want 11", k, ready, sys_reset_n); end
      if (k == 1) begin
        tests++; if (pll_phasesel !== 2'd2 || pll_phasedir !== 1'b0) begin fails++; $display("FAIL ps_capture1 got %0d/%b want 2/0", pll_phasesel, pll_phasedir); end
      end
      if (k == 8) begin ps_sel = 2'd1; ps_dir = 1'b1; end
      if (k == 10) begin
        tests++; if (pll_phasesel !== 2'd1 || pll_phasedir !== 1'b1) begin fails++; $display("FAIL ps_capture2 got %0d/%b want 1/1", pll_phasesel, pll_phasedir); end
      end
      if (k == 17) ps_req = 1'b0;
    end
    ps_sel = 2'd0; ps_dir = 1'b0;
    repeat (3) tick();
    tests++; if (pll_phasesel !== 2'd1 || pll_phasedir !== 1'b1 || pll_phasestep !== 1'b1 || ps_ack !== 1'b0) begin
      fails++; $display("FAIL ps_idle_hold got sel=%0d dir=%b step=%b ack=%b want 1/1/1/0", pll_phasesel, pll_phasedir, pll_phasestep, ps_ack);
    end
  endtask

  task automatic test_lock_loss_run();
    int n;
    pll_locked = 1'b0;
    tick(); tick();
    tests++; if (sys_reset_n !== 1'b1 || ready !== 1'b1) begin fails++; $display("FAIL loss_edge2 got %b%b want 11", sys_reset_n, ready); end
    tick();
    tests++; if (sys_reset_n !== 1'b0 || ready !== 1'b0 || pll_reset !== 1'b1) begin
      fails++; $display("FAIL loss_edge3 got srn=%b rdy=%b rst=%b want 0/0/1", sys_reset_n, ready, pll_reset);
    end
    pll_locked = 1'b1;
    n = 0;
    while (pll_reset === 1'b1 && n < 50) begin n++; tick(); end
    tests++; if (n != 4) begin fails++; $display("FAIL loss_hold_len got %0d want 4", n); end
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
    tests++; if (n != 9) begin fails++; $display("FAIL loss_relock_delay got %0d want 9", n); end
    tests++; if (retry_count !== 4'd0) begin fails++; $display("FAIL loss_retry got %0d want 0", retry_count); end
  endtask

  task automatic test_abort();
    ps_sel = 2'd3; ps_dir = 1'b1; ps_req = 1'b1;
    tick();
    tests++; if (pll_phasesel !== 2'd3 || pll_phasedir !== 1'b1) begin fails++; $display("FAIL abort_capture got %0d/%b want 3/1", pll_phasesel, pll_phasedir); end
    ps_req = 1'b0;
    tick();
    pll_locked = 1'b0;
    tick(); tick();
    tests++; if (pll_phasestep !== 1'b0) begin fails++; $display("FAIL abort_in_pulse got %b want 0", pll_phasestep); end
    tick();
    tests++; if (pll_phasestep !== 1'b1 || pll_reset !== 1'b1) begin fails++; $display("FAIL abort_exit got step=%b rst=%b want 1/1", pll_phasestep, pll_reset); end
    tests++; if (ready !== 1'b0 || sys_reset_n !== 1'b0) begin fails++; $display("FAIL abort_ready got %b%b want 00", ready, sys_reset_n); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (ps_ack !== 1'b0) begin fails++; $display("FAIL abort_no_ack k=%0d got %b want 0", k, ps_ack); end
      tick();
    end
  endtask

  task automatic test_glitch();
    reset_n = 1'b0; pll_locked = 1'b0;
    tick(); tick();
    reset_n = 1'b1; pll_locked = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (t == 7) pll_locked = 1'b0;
      if (t == 8) pll_locked = 1'b1;
      tests++; if (ready !== (t >= 19)) begin fails++; $display("FAIL glitch_ready t=%0d got %b want %b", t, ready, (t >= 19)); end
      tests++; if (pll_reset !== (t <= 3)) begin fails++; $display("FAIL glitch_pll_reset t=%0d got %b want %b", t, pll_reset, (t <= 3)); end
    end
    tests++; if (retry_count !== 4'd0) begin fails++; $display("FAIL glitch_retry got %0d want 0", retry_count); end
  endtask

  task automatic test_never_lock();
    logic exp_rst, exp_fail;
    logic [3:0] exp_retry;
    reset_n = 1'b0; pll_locked = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      exp_rst   = (t <= 3) || (t >= 24 && t <= 27) || (t >= 48);
      exp_retry = (t < 24) ? 4'd0 : (t < 48) ? 4'd1 : 4'd2;
      exp_fail  = (t >= 48);
      tests++; if (pll_reset !== exp_rst) begin fails++; $display("FAIL nolock_pll_reset t=%0d got %b want %b", t, pll_reset, exp_rst); end
      tests++; if (retry_count !== exp_retry) begin fails++; $display("FAIL nolock_retry t=%0d got %0d want %0d", t, retry_count, exp_retry); end
      tests++; if (fail !== exp_fail || sys_reset_n !== 1'b0) begin
        fails++; $display("FAIL nolock_fail t=%0d got fail=%b srn=%b want %b/0", t, fail, sys_reset_n, exp_fail);
      end
    end
    reset_n = 1'b0;
    tick();
    tests++; if (fail !== 1'b0 || retry_count !== 4'd0 || pll_reset !== 1'b1 || pll_phasestep !== 1'b1) begin
      fails++; $display("FAIL nolock_reset got fail=%b retry=%0d rst=%b step=%b want 0/0/1/1", fail, retry_count, pll_reset, pll_phasestep);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_phase_step();
    test_lock_loss_run();
    test_abort();
    test_glitch();
    test_never_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
